cnn_cell_mac: RTL and testbench

- Serial, parametrised successor to the combinational 3x3 cell-equation adder: out = sum(A_k*Y_k) + sum(B_k*U_k) + I over TAPS neighbourhood taps.
- Taps stream in one per cycle through a valid/ready handshake, using two multipliers instead of 2*TAPS multipliers.
- Adds pipelined products, a packet-length check, selectable saturate/wrap output, and a valid/ready result port.
- Sits between the neighbourhood fetch logic and the cell-state update stage.

---
 rtl/cnn_cell_mac_pkg.sv | 49 ++++
 rtl/cnn_cell_mac_if.sv | 43 ++++
 rtl/cnn_cell_mac_tap_mult.sv | 65 ++++++
 rtl/cnn_cell_mac.sv | 201 ++++++++++++++++++++
 tb/tb_cnn_cell_mac.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_cell_mac_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
//   Shared types and constant helpers for the serial CNN cell MAC.
//   - clog2      : ceiling log2 for sizing counters and guard bits
//   - state_e    : control FSM states
//   - acc_w      : accumulator width that can hold any packet without overflow
//   - sat_max/min: signed range limits of an N-bit result
// -----------------------------------------------------------------------------
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

  // Widest product, plus enough guard bits for 2*TAPS products and the bias,
  // plus one extra bit for sign headroom.
  function automatic int acc_w(input int dw_a, input int dw_y, input int dw_b,
                               input int dw_u, input int taps);
    int pa_w;
    int pb_w;
    pa_w = dw_a + dw_y;
    pb_w = dw_b + dw_u + 1;
    return ((pa_w > pb_w) ? pa_w : pb_w) + clog2(2 * taps + 1) + 1;
  endfunction

  function automatic longint sat_max(input int width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/cnn_cell_mac_if.sv
// -----------------------------------------------------------------------------
// cnn_cell_mac_if
//   Tap-stream and result handshake bundle for cnn_cell_mac.
//   Tap side  : in_valid/in_ready/in_last with a_coef, y_in, b_coef, u_in, bias
//   Result side: out_valid/out_ready with out_data, out_sat, out_err
//   modport master : upstream fetch logic + downstream consumer
//   modport slave  : the MAC itself
// -----------------------------------------------------------------------------
interface cnn_cell_mac_if #(
  parameter int DW_A  = 8,
  parameter int DW_Y  = 9,
  parameter int DW_B  = 8,
  parameter int DW_U  = 8,
  parameter int DW_I  = 8,
  parameter int OUT_W = 17
);

  logic                    in_valid;
  logic                    in_ready;
  logic                    in_last;
  logic signed [DW_A-1:0]  a_coef;
  logic signed [DW_Y-1:0]  y_in;
  logic signed [DW_B-1:0]  b_coef;
  logic        [DW_U-1:0]  u_in;
  logic signed [DW_I-1:0]  bias;

  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;
  logic                    out_err;

  modport master (
    output in_valid, in_last, a_coef, y_in, b_coef, u_in, bias, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_err
  );

  modport slave (
    input  in_valid, in_last, a_coef, y_in, b_coef, u_in, bias, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_err
  );

endinterface

// File: rtl/cnn_cell_mac_tap_mult.sv
// -----------------------------------------------------------------------------
// cnn_tap_mult
//   Product stage P: A*Y and B*U for one tap, registered one cycle after the
//   tap transfer, with a matching valid flag.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     i_valid     a tap is transferred this cycle
//     i_a, i_y    signed feedback coefficient / neighbour state
//     i_b, i_u    signed control coefficient / unsigned neighbour input
//     o_pa, o_pb  registered products
//     o_valid     products in o_pa/o_pb belong to a transferred tap
// -----------------------------------------------------------------------------
module cnn_tap_mult #(
  parameter int DW_A = 8,
  parameter int DW_Y = 9,
  parameter int DW_B = 8,
  parameter int DW_U = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_valid,
  input  logic signed [DW_A-1:0]        i_a,
  input  logic signed [DW_Y-1:0]        i_y,
  input  logic signed [DW_B-1:0]        i_b,
  input  logic        [DW_U-1:0]        i_u,
  output logic signed [DW_A+DW_Y-1:0]   o_pa,
  output logic signed [DW_B+DW_U:0]     o_pb,
  output logic                          o_valid
);

  localparam int PA_W = DW_A + DW_Y;
  localparam int PB_W = DW_B + DW_U + 1;

  // U is unsigned: a leading zero lets it share a signed multiplier with B.
  logic signed [DW_U:0]     w_u_ext;
  logic signed [PA_W-1:0]   w_pa;
  logic signed [PB_W-1:0]   w_pb;

  logic signed [PA_W-1:0]   r_pa;
  logic signed [PB_W-1:0]   r_pb;
  logic                     r_valid;

  assign w_u_ext = $signed({1'b0, i_u});
  assign w_pa    = PA_W'(i_a) * PA_W'(i_y);
  assign w_pb    = PB_W'(i_b) * PB_W'(w_u_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pa    <= '0;
      r_pb    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_pa <= w_pa;
        r_pb <= w_pb;
      end
    end
  end

  assign o_pa    = r_pa;
  assign o_pb    = r_pb;
  assign o_valid = r_valid;

endmodule

// File: rtl/cnn_cell_mac.sv
// -----------------------------------------------------------------------------
// cnn_cell_mac
//   Serial cell-equation MAC: out = sum(A_k*Y_k) + sum(B_k*U_k) + I over one
//   packet of up to TAPS taps, one tap per cycle.
//   Pipeline: transfer -> P (products, cnn_tap_mult) -> S (accumulate)
//             -> result register (saturate or wrap).
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     bus         cnn_cell_mac_if.slave: tap stream in, result stream out
//   Parameters: TAPS, DW_A, DW_Y, DW_B, DW_U, DW_I, OUT_W, SAT (1 clamp, 0 wrap)
// -----------------------------------------------------------------------------
import cnn_pkg::*;

module cnn_cell_mac #(
  parameter int TAPS  = 9,
  parameter int DW_A  = 8,
  parameter int DW_Y  = 9,
  parameter int DW_B  = 8,
  parameter int DW_U  = 8,
  parameter int DW_I  = 8,
  parameter int OUT_W = 17,
  parameter bit SAT   = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  cnn_cell_mac_if.slave bus
);

  localparam int PA_W  = DW_A + DW_Y;
  localparam int PB_W  = DW_B + DW_U + 1;
  localparam int ACC_W = acc_w(DW_A, DW_Y, DW_B, DW_U, TAPS);
  localparam int CNT_W = clog2(TAPS + 1);

  localparam logic [CNT_W-1:0] TAPS_C  = CNT_W'(TAPS);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [OUT_W-1:0] SAT_MAX = OUT_W'(sat_max(OUT_W));
  localparam logic [OUT_W-1:0] SAT_MIN = OUT_W'(sat_min(OUT_W));

  state_e                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_drain;
  logic                     r_err;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic signed [OUT_W-1:0]  r_out_data;
  logic                     r_out_sat;
  logic                     r_out_err;

  logic                     w_xfer;
  logic signed [PA_W-1:0]   w_pa;
  logic signed [PB_W-1:0]   w_pb;
  logic                     w_p_valid;
  logic signed [ACC_W-1:0]  w_pa_ext;
  logic signed [ACC_W-1:0]  w_pb_ext;
  logic signed [ACC_W-1:0]  w_bias_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic [CNT_W-1:0]         w_cnt_inc;
  logic                     w_first_err;
  logic                     w_acc_err;
  logic                     w_acc_done;
  logic                     w_ovf;
  logic [OUT_W-1:0]         w_low;
  logic [OUT_W-1:0]         w_res_data;

  assign w_xfer = bus.in_valid & r_in_ready;

  cnn_tap_mult #(
    .DW_A (DW_A),
    .DW_Y (DW_Y),
    .DW_B (DW_B),
    .DW_U (DW_U)
  ) u_tap_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_xfer),
    .i_a     (bus.a_coef),
    .i_y     (bus.y_in),
    .i_b     (bus.b_coef),
    .i_u     (bus.u_in),
    .o_pa    (w_pa),
    .o_pb    (w_pb),
    .o_valid (w_p_valid)
  );

  // Stage S operands, sign-extended to the accumulator width.
  assign w_pa_ext   = {{(ACC_W-PA_W){w_pa[PA_W-1]}}, w_pa};
  assign w_pb_ext   = {{(ACC_W-PB_W){w_pb[PB_W-1]}}, w_pb};
  assign w_bias_ext = {{(ACC_W-DW_I){bus.bias[DW_I-1]}}, bus.bias};
  assign w_sum      = r_acc + w_pa_ext + w_pb_ext;

  // Length checking. A packet of one tap is only correct when TAPS is 1.
  assign w_cnt_inc   = r_cnt + ONE_C;
  assign w_first_err = (TAPS_C == ONE_C) ? ~bus.in_last : bus.in_last;
  assign w_acc_done  = bus.in_last | (w_cnt_inc == TAPS_C);
  assign w_acc_err   = (bus.in_last & (w_cnt_inc < TAPS_C)) |
                       (~bus.in_last & (w_cnt_inc == TAPS_C));

  // Out of range when the bits above the result sign are not all copies of it.
  generate
    if (ACC_W > OUT_W) begin : g_narrow
      logic [ACC_W-OUT_W:0] w_hi;
      assign w_hi  = r_acc[ACC_W-1:OUT_W-1];
      assign w_ovf = ~((&w_hi) | ~(|w_hi));
      assign w_low = r_acc[OUT_W-1:0];
    end else begin : g_wide
      assign w_ovf = 1'b0;
      assign w_low = OUT_W'(r_acc);
    end
  endgenerate

  assign w_res_data = (SAT && w_ovf) ? (r_acc[ACC_W-1] ? SAT_MIN : SAT_MAX)
                                     : w_low;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_drain     <= 1'b0;
      r_err       <= 1'b0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      // Stage S runs whenever P holds a tap; bubbles leave r_acc untouched.
      if (w_p_valid) begin
        r_acc <= w_sum;
      end

      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            // P is empty on a first tap, so the bias load never loses a product.
            r_acc <= w_bias_ext;
            r_cnt <= ONE_C;
            r_err <= w_first_err;
            if (bus.in_last || (TAPS_C == ONE_C)) begin
              r_state    <= DRAIN;
              r_drain    <= 1'b0;
              r_in_ready <= 1'b0;
            end else begin
              r_state <= ACC;
            end
          end
        end

        ACC: begin
          if (w_xfer) begin
            r_cnt <= w_cnt_inc;
            if (w_acc_err) begin
              r_err <= 1'b1;
            end
            if (w_acc_done) begin
              r_state    <= DRAIN;
              r_drain    <= 1'b0;
              r_in_ready <= 1'b0;
            end
          end
        end

        DRAIN: begin
          // First cycle lets S absorb the last product; second registers it.
          r_drain <= 1'b1;
          if (r_drain) begin
            r_out_data  <= w_res_data;
            r_out_sat   <= w_ovf;
            r_out_err   <= r_err;
            r_out_valid <= 1'b1;
            r_state     <= OUT;
          end
        end

        OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_err   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;
  assign bus.out_err   = r_out_err;

endmodule

// File: tb/tb_cnn_cell_mac.sv
// -----------------------------------------------------------------------------
// tb_cnn_cell_mac
//   Drives one tap stream into two MAC instances (clamping and wrapping) and
//   compares each result with an arithmetic model of the cell equation.
// -----------------------------------------------------------------------------
module tb_cnn_cell_mac;

  localparam int TAPS  = 9;
  localparam int DW_A  = 8;
  localparam int DW_Y  = 9;
  localparam int DW_B  = 8;
  localparam int DW_U  = 8;
  localparam int DW_I  = 8;
  localparam int OUT_W = 17;
  localparam longint MOD_V = longint'(1) <<< OUT_W;
  localparam longint MAX_V = (MOD_V / 2) - 1;
  localparam longint MIN_V = -(MOD_V / 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic                    tv_valid = 1'b0;
  logic                    tv_last = 1'b0;
  logic                    tv_oready = 1'b1;
  logic signed [DW_A-1:0]  tv_a = '0;
  logic signed [DW_Y-1:0]  tv_y = '0;
  logic signed [DW_B-1:0]  tv_b = '0;
  logic        [DW_U-1:0]  tv_u = '0;
  logic signed [DW_I-1:0]  tv_bias = '0;

  cnn_cell_mac_if #(.DW_A(DW_A), .DW_Y(DW_Y), .DW_B(DW_B), .DW_U(DW_U),
                    .DW_I(DW_I), .OUT_W(OUT_W)) ifs ();
  cnn_cell_mac_if #(.DW_A(DW_A), .DW_Y(DW_Y), .DW_B(DW_B), .DW_U(DW_U),
                    .DW_I(DW_I), .OUT_W(OUT_W)) ifw ();

  assign ifs.in_valid = tv_valid;  assign ifw.in_valid = tv_valid;
  assign ifs.in_last = tv_last;    assign ifw.in_last = tv_last;
  assign ifs.a_coef = tv_a;        assign ifw.a_coef = tv_a;
  assign ifs.y_in = tv_y;          assign ifw.y_in = tv_y;
  assign ifs.b_coef = tv_b;        assign ifw.b_coef = tv_b;
  assign ifs.u_in = tv_u;          assign ifw.u_in = tv_u;
  assign ifs.bias = tv_bias;       assign ifw.bias = tv_bias;
  assign ifs.out_ready = tv_oready; assign ifw.out_ready = tv_oready;

  cnn_cell_mac #(.TAPS(TAPS), .DW_A(DW_A), .DW_Y(DW_Y), .DW_B(DW_B),
                 .DW_U(DW_U), .DW_I(DW_I), .OUT_W(OUT_W), .SAT(1'b1))
    dut_s (.clk(clk), .rst_n(rst_n), .bus(ifs));

  cnn_cell_mac #(.TAPS(TAPS), .DW_A(DW_A), .DW_Y(DW_Y), .DW_B(DW_B),
                 .DW_U(DW_U), .DW_I(DW_I), .OUT_W(OUT_W), .SAT(1'b0))
    dut_w (.clk(clk), .rst_n(rst_n), .bus(ifw));

  // Tap values of the packet about to be sent.
  int qa[$];
  int qy[$];
  int qb[$];
  int qu[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill_const(input int n, input int a, input int y,
                            input int b, input int u);
    qa.delete(); qy.delete(); qb.delete(); qu.delete();
    for (int k = 0; k < n; k++) begin
      qa.push_back(a); qy.push_back(y); qb.push_back(b); qu.push_back(u);
    end
  endtask

  task automatic fill_rand(input int n);
    qa.delete(); qy.delete(); qb.delete(); qu.delete();
    for (int k = 0; k < n; k++) begin
      qa.push_back(int'($urandom_range(0, 255)) - 128);
      qy.push_back(int'($urandom_range(0, 511)) - 256);
      qb.push_back(int'($urandom_range(0, 255)) - 128);
      qu.push_back(int'($urandom_range(0, 255)));
    end
  endtask

  // Present one tap and hold it until it is taken; acc_cyc is the cycle in
  // which in_valid and in_ready were both high.
  task automatic send_tap(input int a, input int y, input int b, input int u,
                          input int bi, input bit last, output int acc_cyc);
    int guard;
    guard = 0;
    tv_a = DW_A'(a); tv_y = DW_Y'(y); tv_b = DW_B'(b); tv_u = DW_U'(u);
    tv_bias = DW_I'(bi);
    tv_last = last;
    tv_valid = 1'b1;
    while (!ifs.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) chk("tap_accept_timeout", 0, 1);
    acc_cyc = cyc;
    tick();
    tv_valid = 1'b0;
    tv_last = 1'b0;
  endtask

  // Send the queued taps as one packet and check the result. gap < 0 picks
  // 0..2 idle cycles between taps at random; bp is the number of cycles the
  // result is held back with out_ready low.
  task automatic run_packet(input string name, input int n, input bit final_last,
                            input int bi, input int gap, input int bp);
    longint exact;
    longint exp_s;
    longint exp_w;
    bit     exp_sat;
    bit     exp_err;
    int     last_cyc;
    int     guard;
    longint held;
    exact = bi;
    tv_oready = (bp == 0);
    for (int k = 0; k < n; k++) begin
      exact += longint'(qa[k]) * qy[k] + longint'(qb[k]) * qu[k];
      // Bias counts only on the first tap; later taps carry noise there.
      send_tap(qa[k], qy[k], qb[k], qu[k],
               (k == 0) ? bi : int'($urandom_range(0, 255)) - 128,
               (k == n - 1) ? final_last : 1'b0, last_cyc);
      if (k != n - 1) begin
        repeat ((gap < 0) ? int'($urandom_range(0, 2)) : gap) tick();
      end
    end

    exp_err = (final_last && n < TAPS) || (!final_last && n == TAPS);
    exp_sat = (exact > MAX_V) || (exact < MIN_V);
    exp_s = (exact > MAX_V) ? MAX_V : (exact < MIN_V) ? MIN_V : exact;
    exp_w = exact % MOD_V;
    if (exp_w < 0) exp_w += MOD_V;
    if (exp_w > MAX_V) exp_w -= MOD_V;

    guard = 0;
    while (!ifs.out_valid && guard < 20) begin
      chk({name, ".drain_in_ready"}, ifs.in_ready, 0);
      tick();
      guard++;
    end
    if (guard >= 20) chk({name, ".result_timeout"}, 0, 1);
    chk({name, ".latency"}, cyc - last_cyc, 3);
    chk({name, ".data_sat"}, ifs.out_data, exp_s);
    chk({name, ".sat_sat"}, ifs.out_sat, exp_sat);
    chk({name, ".err_sat"}, ifs.out_err, exp_err);
    chk({name, ".valid_wrap"}, ifw.out_valid, 1);
    chk({name, ".data_wrap"}, ifw.out_data, exp_w);
    chk({name, ".sat_wrap"}, ifw.out_sat, exp_sat);
    chk({name, ".err_wrap"}, ifw.out_err, exp_err);
    $display("packet %s taps=%0d bias=%0d exact=%0d sat_data=%0d wrap_data=%0d err=%0d",
             name, n, bi, exact, ifs.out_data, ifw.out_data, ifs.out_err);

    held = ifs.out_data;
    for (int h = 0; h < bp; h++) begin
      tick();
      chk({name, ".bp_valid"}, ifs.out_valid, 1);
      chk({name, ".bp_data"}, ifs.out_data, held);
      chk({name, ".bp_in_ready"}, ifs.in_ready, 0);
    end
    tv_oready = 1'b1;
    tick();
    chk({name, ".done_valid"}, ifs.out_valid, 0);
    chk({name, ".done_in_ready"}, ifs.in_ready, 1);
  endtask

  initial begin
    int c;
    int n;
    bit fl;
    int guard;

    // Reset values
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst.in_ready", ifs.in_ready, 1);
    chk("rst.out_valid", ifs.out_valid, 0);
    chk("rst.out_data", ifs.out_data, 0);
    chk("rst.out_sat", ifs.out_sat, 0);
    chk("rst.out_err", ifs.out_err, 0);
    rst_n = 1'b1;
    tick();

    // Basic sum, then back-to-back to check the next tap is taken at L+4
    fill_const(9, 1, 1, 1, 1);
    run_packet("basic", 9, 1'b1, 0, 0, 0);
    fill_const(9, 1, 1, 1, 1);
    run_packet("basic2", 9, 1'b1, 0, 0, 0);

    // Saturation / wrap: exact sum 586504
    fill_const(9, -128, -256, 127, 255);
    run_packet("sat", 9, 1'b1, 127, 0, 0);

    // Negative result with a bubble after every tap
    fill_rand(9);
    for (int k = 0; k < 9; k++) begin qa[k] = -1; qy[k] = 100; qb[k] = 0; end
    run_packet("neg_bubble", 9, 1'b1, -5, 1, 0);

    // Length errors
    fill_const(4, 1, 2, 0, 0);
    run_packet("short", 4, 1'b1, 0, 0, 0);
    fill_const(9, 1, 2, 0, 0);
    run_packet("nolast", 9, 1'b0, 0, 0, 0);

    // Backpressure
    fill_const(9, 1, 1, 1, 1);
    run_packet("backpressure", 9, 1'b1, 0, 0, 5);

    // Reset after tap 5, then a clean packet
    fill_const(9, 1, 1, 1, 1);
    for (int k = 0; k < 5; k++) send_tap(1, 1, 1, 1, 0, 1'b0, c);
    rst_n = 1'b0;
    #1;
    chk("midrst.in_ready", ifs.in_ready, 1);
    chk("midrst.out_valid", ifs.out_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_packet("after_rst", 9, 1'b1, 0, 0, 0);

    // Reset while a result is held: outputs clear without waiting for an edge
    tv_oready = 1'b0;
    fill_const(9, 3, 5, 2, 7);
    for (int k = 0; k < 9; k++) send_tap(3, 5, 2, 7, 1, (k == 8), c);
    guard = 0;
    while (!ifs.out_valid && guard < 20) begin tick(); guard++; end
    chk("outrst.pre_valid", ifs.out_valid, 1);
    chk("outrst.pre_data", ifs.out_data, 9 * (15 + 14) + 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("outrst.out_valid", ifs.out_valid, 0);
    chk("outrst.out_data", ifs.out_data, 0);
    chk("outrst.in_ready", ifs.in_ready, 1);
    tick();
    rst_n = 1'b1;
    tv_oready = 1'b1;
    tick();

    // Random packets with random lengths, bubbles and backpressure
    for (int p = 0; p < 6; p++) begin
      n = int'($urandom_range(1, TAPS));
      fl = (n < TAPS) ? 1'b1 : 1'($urandom_range(0, 1));
      fill_rand(n);
      run_packet($sformatf("rand%0d", p), n, fl, int'($urandom_range(0, 255)) - 128,
                 -1, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=0", 1);
    $fatal(1, "timeout");
  end

endmodule
